// File: rtl/hex_scroll_if.sv
// Signal bundle between the switch/key logic (master) and the hex_scroll display block (slave).
// No valid/ready pair: load is a one-cycle strobe, run is a level, and step qualifies a change of cur.
interface hex_scroll_if #(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 3
);
    logic [VAL_W-1:0]        base;
    logic                    load;
    logic                    run;
    logic                    dir;
    logic [NUM_DIGITS*7-1:0] seg;
    logic [VAL_W-1:0]        cur;
    logic                    step;
    logic                    running;

    modport master (
        output base, load, run, dir,
        input  seg, cur, step, running
    );

    modport slave (
        input  base, load, run, dir,
        output seg, cur, step, running
    );
endinterface

// File: rtl/hex_scroll.sv
// Multi-digit seven-segment scroller: loadable centre value, self-stepping window, registered HEX outputs.
// Optional HEX_SCROLL_BLINK_EN: blinks the display in IDLE using the free-running prescaler.
module hex_scroll #(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 3,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    hex_scroll_if.slave  hex_io
);
    localparam int            PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [VAL_W-1:0]        cur_q, cur_d;
    logic                    step_q, step_d;
    logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
    logic [NUM_DIGITS*7-1:0] dec_all;
    logic                    state_chg;
    logic                    counting;
    logic                    tc;
    logic                    blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Digit k shows cur + NUM_DIGITS/2 - k; negative offsets wrap via truncation.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        localparam logic [VAL_W-1:0] OFF = VAL_W'(NUM_DIGITS / 2 - k);
        logic [VAL_W-1:0] val;
        assign val                = cur_q + OFF;
        assign dec_all[7*k +: 7]  = hex7(4'(val));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hex_io.run)  state_d = RUN;
            RUN:     if (!hex_io.run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state_chg = (state_d != state_q);
`ifdef HEX_SCROLL_BLINK_EN
        counting  = 1'b1;
`else
        counting  = (state_q == RUN);
`endif
        tc        = counting && (presc_q == TC);
        presc_d   = presc_q;
        cur_d     = cur_q;
        step_d    = 1'b0;
        if (hex_io.load || state_chg || !counting) presc_d = '0;
        else if (tc)                              presc_d = '0;
        else                                      presc_d = presc_q + PW'(1);
        // Load wins over a coincident step; a step on the cycle run drops is dropped.
        if (hex_io.load) begin
            cur_d = hex_io.base;
        end else if (tc && state_q == RUN && !state_chg) begin
            cur_d  = hex_io.dir ? cur_q - VAL_W'(1) : cur_q + VAL_W'(1);
            step_d = 1'b1;
        end
        seg_d = blank ? '1 : dec_all;
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (hex_io.load || state_chg || state_q == RUN) phase_d = 1'b0;
        else if (tc)                                    phase_d = ~phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 1'b0;
        else        phase_q <= phase_d;
    end

    assign blank = phase_q;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cur_q   <= '0;
            step_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            presc_q <= presc_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            seg_q   <= seg_d;
        end
    end

    assign hex_io.seg     = seg_q;
    assign hex_io.cur     = cur_q;
    assign hex_io.step    = step_q;
    assign hex_io.running = (state_q == RUN);
endmodule

// File: tb/tb_hex_scroll.sv
// Directed bench for hex_scroll (8 digits, 3-bit values, 4-cycle step period) with a step scoreboard.
module tb_hex_scroll;
    localparam int ND = 8;
    localparam int VW = 3;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_scroll_if #(.NUM_DIGITS(ND), .VAL_W(VW)) hif ();

    hex_scroll #(.NUM_DIGITS(ND), .VAL_W(VW), .TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hex_io (hif)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [VW-1:0] exp_q [$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [ND*7-1:0] exp_seg(input logic [VW-1:0] c);
        logic [ND*7-1:0] r;
        logic [VW-1:0]   v;
        for (int k = 0; k < ND; k++) begin
            v            = c + VW'(ND / 2 - k);
            r[7*k +: 7]  = seg_tab[{1'b0, v}];
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every step pulse must match the next expected centre value.
    always @(posedge clk) begin
        logic [VW-1:0] e;
        #1;
        if (rst_n && hif.step) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_step: step=1 cur=%0d, expected no step", hif.cur);
            end else begin
                e = exp_q.pop_front();
                if (hif.cur === e) n_pass++;
                else $display("FAIL step_cur: got %0d expected %0d", hif.cur, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.base = '0;
        hif.load = 1'b0;
        hif.run  = 1'b0;
        hif.dir  = 1'b0;
        rst_n    = 1'b0;
        tick(2);
        check("rst_seg", hif.seg, {ND*7{1'b1}});
        check("rst_cur", hif.cur, 0);
        check("rst_step", hif.step, 0);
        check("rst_running", hif.running, 0);

        rst_n = 1'b1;
        tick(1);
        check("post_rst_seg", hif.seg, exp_seg(0));

        hif.load = 1'b1; hif.base = 3'd0;
        tick(1);
        hif.load = 1'b0;
        check("load0_cur", hif.cur, 0);
        tick(1);
        check("load0_seg", hif.seg, {7'h12, 7'h02, 7'h78, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});

        // Count up: steps land 4 and 8 edges after run is sampled.
        hif.dir = 1'b0; hif.run = 1'b1;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        tick(1);
        check("up_running", hif.running, 1);
        tick(3);
        check("up_pre_cur", hif.cur, 0);
        tick(1);
        check("up_cur1", hif.cur, 1);
        tick(4);
        check("up_cur2", hif.cur, 2);
        check("up_dig4_lag", hif.seg[34:28], 7'h79);
        hif.run = 1'b0;
        tick(1);
        check("up_dig4", hif.seg[34:28], 7'h24);
        check("stop_running", hif.running, 0);

        // Count down from 0 wraps to 7.
        hif.load = 1'b1; hif.base = 3'd0;
        tick(1);
        hif.load = 1'b0; hif.dir = 1'b1; hif.run = 1'b1;
        exp_q.push_back(3'd7);
        tick(1);
        tick(4);
        check("down_cur", hif.cur, 7);
        hif.run = 1'b0;
        tick(1);
        check("down_dig0", hif.seg[6:0], 7'h30);
        check("down_dig7", hif.seg[55:49], 7'h19);

        // Load on the terminal-count cycle beats the step.
        hif.dir = 1'b0; hif.run = 1'b1;
        tick(1);
        tick(3);
        hif.load = 1'b1; hif.base = 3'd5;
        tick(1);
        hif.load = 1'b0;
        check("tc_load_cur", hif.cur, 5);
        check("tc_load_nostep", hif.step, 0);
        exp_q.push_back(3'd6);
        tick(3);
        check("tc_load_hold", hif.cur, 5);
        tick(1);
        check("tc_next_step", hif.cur, 6);

        // Asynchronous reset in the middle of a run.
        tick(1);
        rst_n = 1'b0;
        #1;
        check("arst_cur", hif.cur, 0);
        check("arst_running", hif.running, 0);
        check("arst_seg", hif.seg, {ND*7{1'b1}});
        hif.run = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("arst_hold_cur", hif.cur, 0);
        check("arst_hold_running", hif.running, 0);
        hif.run = 1'b1;
        exp_q.push_back(3'd1);
        tick(1);
        check("rerun_running", hif.running, 1);
        tick(4);
        check("rerun_cur", hif.cur, 1);
        hif.run = 1'b0;
        tick(1);

        // Idle display: steady by default, blinking every 4 cycles when enabled.
        hif.load = 1'b1; hif.base = 3'd3;
        tick(1);
        hif.load = 1'b0;
        tick(1);
        for (int j = 2; j < 18; j++) begin
            tick(1);
            check("idle_cur", hif.cur, 3);
`ifdef HEX_SCROLL_BLINK_EN
            check("idle_seg", hif.seg, (((j - 1) / 4) % 2 == 1) ? {ND*7{1'b1}} : exp_seg(3));
`else
            check("idle_seg", hif.seg, exp_seg(3));
`endif
        end

        check("steps_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
